// File: rtl/paula_iack_ctrl.sv
// -----------------------------------------------------------------------------
// paula_iack_ctrl
//
// Interrupt sequencer between the Paula interrupt controller and the 68k core.
// Filters Paula's active-low priority level before it reaches the CPU and runs
// the CPU interrupt-acknowledge handshake with a programmable autovector delay.
// The acknowledge returns the autovector (25..31) or the spurious vector (24)
// when the requested level is no longer pending. State advances only on
// clk7_en cycles; _reset is the only asynchronous path.
//
// Build option:
//   IPL_FILTER_EN  defined   : _ipl_out changes only after FILTER_LEN identical
//                              consecutive samples of _ipl_in.
//                  undefined : _ipl_out follows _ipl_in with one tick latency;
//                              FILTER_LEN has no effect.
//
// Parameters:
//   FILTER_LEN  1..7   identical samples needed before _ipl_out changes
//   ACK_DELAY   1..15  ticks from IACK start to iack_dtack
//
// Ports:
//   clk         in   bus clock
//   _reset      in   asynchronous active-low reset
//   clk7_en     in   clock enable qualifying every register update
//   _ipl_in     in   [2:0] active-low level from the interrupt controller
//   _ipl_out    out  [2:0] filtered active-low level to the CPU
//   iack_req    in   CPU acknowledge cycle in progress
//   iack_level  in   [2:0] level being acknowledged (active-high)
//   iack_dtack  out  acknowledge complete, vector valid
//   vector      out  [7:0] exception vector number
//   spurious    out  current acknowledge returned the spurious vector
// -----------------------------------------------------------------------------
module paula_iack_ctrl #(
    parameter int unsigned FILTER_LEN = 2,
    parameter int unsigned ACK_DELAY  = 4
) (
    input  logic       clk,
    input  logic       _reset,
    input  logic       clk7_en,
    input  logic [2:0] _ipl_in,
    output logic [2:0] _ipl_out,
    input  logic       iack_req,
    input  logic [2:0] iack_level,
    output logic       iack_dtack,
    output logic [7:0] vector,
    output logic       spurious
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_RELEASE
    } state_e;

    localparam logic [3:0] DLY_LOAD   = 4'(ACK_DELAY - 1);
    localparam logic [7:0] VEC_SPUR   = 8'd24;

    state_e     state_q, state_d;
    logic [2:0] ack_lvl_q, ack_lvl_d;
    logic [3:0] dly_cnt_q, dly_cnt_d;
    logic [2:0] ipl_q, ipl_d;
    logic       dtack_q, dtack_d;
    logic [7:0] vector_q, vector_d;
    logic       spurious_q, spurious_d;

    logic [2:0] lvl;
    logic       level_hit;

    assign _ipl_out   = ipl_q;
    assign iack_dtack = dtack_q;
    assign vector     = vector_q;
    assign spurious   = spurious_q;

    // Level currently presented to the CPU; the vector decision uses the
    // registered value, so a late change only matters if it has already
    // propagated through the filter.
    assign lvl       = ~ipl_q;
    assign level_hit = (ack_lvl_q != 3'd0) && (lvl >= ack_lvl_q);

    // ------------------------------------------------------------------
    // IPL path
    // ------------------------------------------------------------------
`ifdef IPL_FILTER_EN
    localparam logic [2:0] FILT_MAX = 3'(FILTER_LEN);

    logic [2:0] samp_q, samp_d;
    logic [2:0] stable_cnt_q, stable_cnt_d;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise a path that skips an assignment infers a latch.
        samp_d       = _ipl_in;
        stable_cnt_d = stable_cnt_q;
        ipl_d        = ipl_q;
        if (_ipl_in == samp_q) begin
            if (stable_cnt_q != FILT_MAX) begin
                stable_cnt_d = stable_cnt_q + 3'd1;
            end
        end else begin
            stable_cnt_d = 3'd1;
        end
        // Decide on the updated count so the output moves on the tick the
        // run length reaches FILTER_LEN, not one tick later.
        if ((stable_cnt_d == FILT_MAX) && (_ipl_in != ipl_q)) begin
            ipl_d = _ipl_in;
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            samp_q       <= 3'b111;
            stable_cnt_q <= 3'd0;
        end else if (clk7_en) begin
            samp_q       <= samp_d;
            stable_cnt_q <= stable_cnt_d;
        end
    end
`else
    assign ipl_d = _ipl_in;

    // FILTER_LEN is accepted for a uniform interface but has no effect here.
    if (FILTER_LEN == 0) begin : g_filter_len_unused
    end
`endif

    // ------------------------------------------------------------------
    // Acknowledge FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ack_lvl_d  = ack_lvl_q;
        dly_cnt_d  = dly_cnt_q;
        dtack_d    = dtack_q;
        vector_d   = vector_q;
        spurious_d = spurious_q;
        case (state_q)
            ST_IDLE: begin
                if (iack_req) begin
                    ack_lvl_d = iack_level;
                    dly_cnt_d = DLY_LOAD;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A bus abort wins over the evaluation tick.
                if (!iack_req) begin
                    state_d = ST_IDLE;
                end else if (dly_cnt_q == 4'd0) begin
                    state_d = ST_ACK;
                    dtack_d = 1'b1;
                    if (level_hit) begin
                        vector_d   = VEC_SPUR + {5'd0, ack_lvl_q};
                        spurious_d = 1'b0;
                    end else begin
                        vector_d   = VEC_SPUR;
                        spurious_d = 1'b1;
                    end
                end else begin
                    dly_cnt_d = dly_cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                if (!iack_req) begin
                    state_d    = ST_RELEASE;
                    dtack_d    = 1'b0;
                    vector_d   = 8'd0;
                    spurious_d = 1'b0;
                end
            end
            ST_RELEASE: begin
                // One dead tick: a request still high here is not accepted.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q    <= ST_IDLE;
            ack_lvl_q  <= 3'd0;
            dly_cnt_q  <= 4'd0;
            ipl_q      <= 3'b111;
            dtack_q    <= 1'b0;
            vector_q   <= 8'd0;
            spurious_q <= 1'b0;
        end else if (clk7_en) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q    <= state_d;
            ack_lvl_q  <= ack_lvl_d;
            dly_cnt_q  <= dly_cnt_d;
            ipl_q      <= ipl_d;
            dtack_q    <= dtack_d;
            vector_q   <= vector_d;
            spurious_q <= spurious_d;
        end
    end

endmodule

// File: tb/tb_paula_iack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_paula_iack_ctrl
//
// Self-checking bench for paula_iack_ctrl. A transaction-level model (sample
// history for the IPL path, tick-stamped request bookkeeping for the
// acknowledge) predicts the outputs; every clock the DUT is compared against
// it. Directed scenarios add literal expectations, then a randomized phase
// exercises enables, level changes, aborts and resets.
// -----------------------------------------------------------------------------
module tb_paula_iack_ctrl;

    localparam int unsigned FL = 2;
    localparam int unsigned AD = 4;
`ifdef IPL_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] ipl_in;
    logic [2:0] ipl_out;
    logic       req;
    logic [2:0] lvl_in;
    logic       dtack;
    logic [7:0] vector;
    logic       spurious;

    paula_iack_ctrl #(
        .FILTER_LEN (FL),
        .ACK_DELAY  (AD)
    ) dut (
        .clk        (clk),
        ._reset     (rst_n),
        .clk7_en    (en),
        ._ipl_in    (ipl_in),
        ._ipl_out   (ipl_out),
        .iack_req   (req),
        .iack_level (lvl_in),
        .iack_dtack (dtack),
        .vector     (vector),
        .spurious   (spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [2:0] hist[$];   // samples of _ipl_in since reset
    logic [2:0] m_ipl;
    int         n;         // enabled-tick index
    int         t_start;
    int         t_free;    // requests accepted only on ticks after this one
    bit         pend;
    bit         acked;
    logic [2:0] m_ack_lvl;
    logic [7:0] e_vec;
    bit         e_sp;

    task automatic model_reset();
        hist.delete();
        m_ipl     = 3'b111;
        pend      = 1'b0;
        acked     = 1'b0;
        t_free    = n - 1;
        m_ack_lvl = 3'd0;
        e_vec     = 8'd0;
        e_sp      = 1'b0;
    endtask

    task automatic model_step();
        logic [2:0] cur;
        bit         hit;
        bit         same;
        cur = ~m_ipl;
        if (acked) begin
            if (!req) begin
                acked  = 1'b0;
                pend   = 1'b0;
                t_free = n + 1;
            end
        end else if (pend) begin
            if (!req) begin
                pend   = 1'b0;
                t_free = n;
            end else if (n == t_start + int'(AD)) begin
                hit   = (m_ack_lvl != 0) && (cur >= m_ack_lvl);
                acked = 1'b1;
                e_vec = hit ? 8'(24 + int'(m_ack_lvl)) : 8'd24;
                e_sp  = !hit;
            end
        end else if (req && n > t_free) begin
            pend      = 1'b1;
            t_start   = n;
            m_ack_lvl = lvl_in;
        end
        hist.push_back(ipl_in);
        if (hist.size() > 8) void'(hist.pop_front());
        if (FILT) begin
            if (hist.size() >= int'(FL)) begin
                same = 1'b1;
                for (int k = 1; k < int'(FL); k++)
                    if (hist[hist.size() - 1 - k] != hist[hist.size() - 1]) same = 1'b0;
                if (same) m_ipl = hist[hist.size() - 1];
            end
        end else begin
            m_ipl = ipl_in;
        end
        n++;
    endtask

    // One clock: model advances on the edge, DUT compared 1 ns later, then
    // control returns at the following falling edge where inputs change.
    task automatic cyc();
        @(posedge clk);
        if (!rst_n) model_reset();
        else if (en) model_step();
        #1;
        check("ipl_out",  32'(ipl_out),  32'(m_ipl));
        check("dtack",    32'(dtack),    32'(acked));
        check("vector",   32'(vector),   acked ? 32'(e_vec) : 32'd0);
        check("spurious", 32'(spurious), 32'(acked & e_sp));
        @(negedge clk);
    endtask

    task automatic ticks(input int k);
        repeat (k) cyc();
    endtask

    initial begin
        n = 0;
        model_reset();
        rst_n  = 1'b0;
        en     = 1'b1;
        ipl_in = 3'b111;
        req    = 1'b0;
        lvl_in = 3'd0;
        ticks(3);
        check("reset_ipl",      32'(ipl_out),  32'h7);
        check("reset_dtack",    32'(dtack),    32'h0);
        check("reset_vector",   32'(vector),   32'h0);
        check("reset_spurious", 32'(spurious), 32'h0);
        rst_n = 1'b1;
        ticks(3);

        // Glitch rejection, then a held level.
        ipl_in = 3'b101; ticks(1);
        check("glitch_tick", 32'(ipl_out), FILT ? 32'h7 : 32'h5);
        ipl_in = 3'b111; ticks(1);
        check("glitch_gone", 32'(ipl_out), 32'h7);
        ipl_in = 3'b101; ticks(1);
        check("hold_1", 32'(ipl_out), FILT ? 32'h7 : 32'h5);
        ticks(1);
        check("hold_2", 32'(ipl_out), 32'h5);
        ticks(1);

        // Normal acknowledge at level 3.
        ipl_in = 3'b100; ticks(3);
        check("lvl3_ipl", 32'(ipl_out), 32'h4);
        req = 1'b1; lvl_in = 3'd3; ticks(4);
        check("ack_not_yet", 32'(dtack), 32'h0);
        ticks(1);
        check("ack_dtack",    32'(dtack),    32'h1);
        check("ack_vector",   32'(vector),   32'd27);
        check("ack_spurious", 32'(spurious), 32'h0);
        req = 1'b0; ticks(2);
        check("rel_dtack",  32'(dtack),  32'h0);
        check("rel_vector", 32'(vector), 32'h0);
        ticks(2);

        // Spurious: level withdrawn before the evaluation tick.
        ipl_in = 3'b001; ticks(3);
        check("lvl6_ipl", 32'(ipl_out), 32'h1);
        req = 1'b1; lvl_in = 3'd6; ticks(1);
        ipl_in = 3'b111; ticks(4);
        check("spur_dtack",    32'(dtack),    32'h1);
        check("spur_vector",   32'(vector),   32'd24);
        check("spur_spurious", 32'(spurious), 32'h1);
        req = 1'b0; ticks(4);

        // Abort during WAIT, then a normal acknowledge.
        ipl_in = 3'b100; ticks(3);
        req = 1'b1; lvl_in = 3'd3; ticks(2);
        req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ticks(1);
            check("abort_no_dtack", 32'(dtack), 32'h0);
        end
        req = 1'b1; ticks(4);
        check("post_abort_early", 32'(dtack), 32'h0);
        ticks(1);
        check("post_abort_dtack",  32'(dtack),  32'h1);
        check("post_abort_vector", 32'(vector), 32'd27);
        req = 1'b0; ticks(4);

        // Stall: clk7_en low for 10 clocks inside WAIT.
        req = 1'b1; lvl_in = 3'd3; ticks(1);
        en = 1'b0; ticks(10);
        en = 1'b1; ticks(3);
        check("stall_not_yet", 32'(dtack), 32'h0);
        ticks(1);
        check("stall_dtack",  32'(dtack),  32'h1);
        check("stall_vector", 32'(vector), 32'd27);
        req = 1'b0; ticks(4);

        // Asynchronous reset in the middle of WAIT.
        ipl_in = 3'b010; ticks(3);
        check("lvl5_ipl", 32'(ipl_out), 32'h2);
        req = 1'b1; lvl_in = 3'd5; ticks(2);
        rst_n = 1'b0; req = 1'b0;
        #1;
        check("async_rst_ipl",    32'(ipl_out), 32'h7);
        check("async_rst_dtack",  32'(dtack),   32'h0);
        check("async_rst_vector", 32'(vector),  32'h0);
        @(negedge clk);
        ticks(1);
        rst_n = 1'b1; ticks(1);
        check("rst_rel_1", 32'(ipl_out), FILT ? 32'h7 : 32'h2);
        ticks(1);
        check("rst_rel_2", 32'(ipl_out), 32'h2);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            en = ($urandom_range(0, 3) != 0);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
            if ($urandom_range(0, 3) == 0)
                ipl_in = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 7)) : 3'b111;
            if (!req) begin
                if ($urandom_range(0, 7) == 0) begin
                    req    = 1'b1;
                    lvl_in = ($urandom_range(0, 2) != 0) ? ~ipl_in : 3'($urandom_range(0, 7));
                end
            end else if (dtack) begin
                if ($urandom_range(0, 1) != 0) req = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                req = 1'b0;
            end
            ticks(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
